// File: rtl/window_buffer.sv
// Sliding 8-channel x 5-deep sample window feeding a downstream convolution.
// A window is issued once the history is full and the stride count is met; it is held until i_conv_done.
module window_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned STRIDE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample [0:7],
    output logic              o_ready,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_data [0:39],
    output logic              o_start,
    input  logic              i_conv_done,
    output logic              o_busy
);

    localparam int unsigned N_CH  = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned N_EL  = N_CH * DEPTH;
    localparam logic [2:0]  FULL_CNT   = 3'd5;
    localparam logic [2:0]  STRIDE_CNT = 3'(STRIDE);

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q [0:N_EL-1];
    logic [DATA_W-1:0] buf_d [0:N_EL-1];
    logic [2:0]        fill_cnt_q, fill_cnt_d;
    logic [2:0]        stride_cnt_q, stride_cnt_d;
    logic [2:0]        fill_cnt_inc, stride_cnt_inc;
    logic              first_q, first_d;
    logic              accept;

    always_comb begin
        o_ready = i_rst_n && !i_flush && (state_q == S_FILL);
        accept  = i_valid && o_ready;
        o_start = (state_q == S_START);
        o_busy  = (state_q != S_FILL);
        o_data  = buf_q;
    end

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        fill_cnt_d     = fill_cnt_q;
        stride_cnt_d   = stride_cnt_q;
        first_d        = first_q;
        fill_cnt_inc   = (fill_cnt_q == FULL_CNT) ? FULL_CNT : fill_cnt_q + 3'd1;
        stride_cnt_inc = stride_cnt_q + 3'd1;

        if (i_flush) begin
            buf_d        = '{default: '0};
            fill_cnt_d   = '0;
            stride_cnt_d = '0;
            first_d      = 1'b1;
            state_d      = S_FILL;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (accept) begin
                        for (int unsigned c = 0; c < N_CH; c++) begin
                            for (int unsigned t = 0; t < DEPTH - 1; t++) begin
                                buf_d[c*DEPTH + t] = buf_q[c*DEPTH + t + 1];
                            end
                            buf_d[c*DEPTH + DEPTH - 1] = i_sample[c];
                        end
                        fill_cnt_d   = fill_cnt_inc;
                        stride_cnt_d = stride_cnt_inc;
                        // The first window after reset/flush ignores the stride count.
                        if (fill_cnt_inc == FULL_CNT &&
                            (first_q || stride_cnt_inc == STRIDE_CNT)) begin
                            state_d      = S_START;
                            stride_cnt_d = '0;
                            first_d      = 1'b0;
                        end
                    end
                end
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    if (i_conv_done) state_d = S_FILL;
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_FILL;
            buf_q        <= '{default: '0};
            fill_cnt_q   <= '0;
            stride_cnt_q <= '0;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            fill_cnt_q   <= fill_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            first_q      <= first_d;
        end
    end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter DATA_W, default 16, is the width of one sensor sample in bits.
REQ-002 Parameter STRIDE, default 1, legal 1..5, is the number of accepted samples between successive windows once the buffer is full.
REQ-003 Port i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  is the reset: synchronous and active-low.
REQ-005 Port i_valid  input  1  means upstream presents a sample this cycle.
REQ-006 Port i_sample  input  [DATA_W-1:0] x [0:7]  is one 8-channel sensor sample.
REQ-007 Port o_ready  output  1  means the block accepts i_sample this cycle.
REQ-008 Port i_flush  input  1  discards all buffered history.
REQ-009 Port o_data  output  [DATA_W-1:0] x [0:39]  is the window, index c*5+t, where c is channel 0..7 and t is time 0 (oldest) .. 4 (newest).
REQ-010 Port o_start  output  1  is a one-cycle pulse that launches the downstream convolution.
REQ-011 Port i_conv_done  input  1  is the downstream convolution-finished pulse.
REQ-012 Port o_busy  output  1  is high while a window is issued and not yet consumed.

Function
REQ-013 A sample is accepted when i_valid and o_ready are both high in the same cycle.
REQ-014 On accept, every channel c SHALL shift: buf[c][t] <= buf[c][t+1] for t=0..3, and buf[c][4] <= i_sample[c].
REQ-015 o_data SHALL be driven directly from the buffer registers, bit-exact, with no arithmetic.
REQ-016 fill_cnt (3 bits) SHALL increment on each accept and saturate at 5.
REQ-017 stride_cnt (3 bits) SHALL increment on each accept and be cleared when a window is issued.
REQ-018 The state machine SHALL have three states: S_FILL, S_START and S_WAIT.
REQ-019 S_FILL: o_ready=1 unless i_flush=1. After an accept, if the updated fill_cnt==5 and (this is the first window since reset/flush, or the updated stride_cnt==STRIDE), the next state SHALL be S_START.
REQ-020 S_START: o_start=1 for exactly this one cycle and o_ready=0; the next state SHALL be S_WAIT unconditionally.
REQ-021 S_WAIT: o_ready=0 and o_data held stable; i_conv_done=1 SHALL move the state to S_FILL.
REQ-022 Latency: with the accept in cycle N, updated o_data and o_start=1 SHALL both appear in cycle N+1.
REQ-023 o_busy SHALL equal (state != S_FILL).
REQ-024 i_conv_done SHALL be ignored in S_FILL and S_START.
REQ-025 If i_valid is high while o_ready is low, the sample is not accepted and upstream holds it; this includes the cycle in which i_conv_done arrives.
REQ-026 i_flush=1 in any state SHALL, next cycle, zero the buffer, clear fill_cnt and stride_cnt, enter S_FILL, hold o_start=0, and re-arm the first-window condition.
REQ-027 If i_flush and i_valid are high in the same cycle, o_ready SHALL be 0 and the sample dropped.
REQ-028 A partially filled buffer (fill_cnt<5) SHALL never produce o_start.

Reset
REQ-029 While i_rst_n=0 at a clock edge, the block SHALL clear the buffer (all o_data=0), clear fill_cnt and stride_cnt, enter S_FILL, set o_start=0 and o_busy=0, and re-arm the first-window condition.
REQ-030 o_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-031 Reset asserted in S_START or S_WAIT SHALL abandon the window; no o_start follows until 5 new samples are accepted.
REQ-032 Reset SHALL take priority over i_flush, i_valid and i_conv_done.

Verification
REQ-033 Reset, then accept 5 samples, sample k with channel c = 16*c+k -> o_start=1 one cycle after the 5th accept, and o_data[c*5+t] = 16*c+t.
REQ-034 STRIDE=1: after scenario REQ-033, pulse i_conv_done, then accept sample k=5 -> o_start next cycle, and o_data[c*5+t] = 16*c+t+1.
REQ-035 Hold i_valid=1 for 10 cycles in S_WAIT -> o_ready=0 and o_data unchanged throughout; the held sample is accepted in the first cycle after the i_conv_done cycle.
REQ-036 STRIDE=2: after the first window and done, one accept -> no o_start; a second accept -> o_start, and o_data[c*5+t] = 16*c+t+2.
REQ-037 Accept 3 samples, assert i_flush for one cycle -> o_data all 0, and o_start only after 5 further accepts.
REQ-038 Drop i_rst_n for one cycle during S_WAIT -> o_busy=0, o_data all 0, o_ready=1 next cycle, and no o_start for the next 4 accepts.
